hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor of the pipeline hazard unit.
- Takes pre-decoded operand-use flags instead of opcodes, so it is independent of the ISA.
- Generalises register-id width and forwarding modes.
- Adds a variable-latency memory stall FSM, wrong-path fetch squashing, and saturating hazard performance counters.
- Sits beside the ID stage; drives PC/IR enables, the ID bubble, the IF flush and a whole-pipe freeze.

Parameters:
- REG_ADDR_W, 2, width of register ids.
- DATA_FORWARDING, 1, 1 means EX/MEM results are forwarded; 0 means stall on any RAW hazard.
- RF_SELF_FORWARDING, 1, 1 means the register file bypasses the WB write; 0 means WB RAW also stalls.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- use_rs, use_rt, use_rs_at_id  in  1 each  operand-use flags from the decoder (use_rs_at_id is set for JPR/JRL).
- rs_id, rt_id  in  REG_ADDR_W each  ID-stage source register ids.
- reg_write_ex, reg_write_mem, reg_write_wb  in  1 each  destination write enable per stage.
- write_reg_ex, write_reg_mem, write_reg_wb  in  REG_ADDR_W each  destination register id per stage.
- d_mem_read_ex, d_mem_read_mem, d_mem_read_wb  in  1 each  stage holds a load.
- jump_miss, branch_miss  in  1 each  redirect requests.
- i_mem_busy  in  1  instruction fetch not yet complete; the fetched word stays valid while PC is held.
- d_mem_busy  in  1  MEM-stage access not yet complete.
- count_clear  in  1  synchronous counter clear.
- pc_write, ir_write, bubblify, flush_if  out  1 each  front-end controls.
- stall_pipe  out  1  freeze all of ID/EX, EX/MEM and MEM/WB.
- incr_num_inst  out  1  count a retired instruction.
- stall_cycles, redirect_count  out  CNT_W each  performance counters.
- fsm_state  out  2  debug view of the FSM state.

Behaviour:
- Outputs are combinational from inputs and state; the counters and state are registered.
- While reset is high:
  - pc_write=0, ir_write=0, bubblify=1, flush_if=1, stall_pipe=0, incr_num_inst=0.
  - Next state is RUN and both counters are 0.
- Data stall (DS), OR of the following terms:
  - Load-use: (use_rs && rs_id==write_reg_ex || use_rt && rt_id==write_reg_ex) && d_mem_read_ex.
  - Produce-jump: use_rs_at_id && reg_write_ex && rs_id==write_reg_ex, and the same with mem.
  - Only when !DATA_FORWARDING: the RAW terms on ex and mem for rs/rt, and the load term on mem.
  - Only when !RF_SELF_FORWARDING: the RAW terms on wb and the load term on wb.
- Control priority per cycle is freeze > DS > redirect > ifetch wait.
  1. d_mem_busy: stall_pipe=1, pc_write=0, ir_write=0, bubblify=0, flush_if=0. The state and redirect inputs are held.
  2. DS: pc_write=0, ir_write=0, bubblify=1. No state change.
  3. Redirect (jump_miss or branch_miss):
     - pc_write=1, flush_if=1.
     - bubblify=branch_miss.
     - If i_mem_busy, next state is ISQUASH; otherwise RUN.
  4. i_mem_busy with no redirect: pc_write=0, ir_write=1, flush_if=1 (IR loads a nop). Next state is IWAIT, or stays ISQUASH if already there.
  5. Otherwise the defaults apply: pc_write=1, ir_write=1, others 0. Next state is RUN.
- FSM states are RUN=0, IWAIT=1, ISQUASH=2.
  - IWAIT differs from RUN only in fsm_state.
  - ISQUASH: the first cycle with !i_mem_busy, not frozen and not DS delivers a wrong-path word. That cycle forces flush_if=1 and pc_write=1, and the state goes to RUN.
  - A new redirect in ISQUASH with i_mem_busy stays in ISQUASH.
- incr_num_inst = !(bubblify || flush_if || stall_pipe).
- stall_cycles: +1 on every non-reset cycle with pc_write==0.
- redirect_count: +1 on every accepted redirect cycle (item 3 taken).
- Both counters saturate at all-ones; count_clear zeroes them and has priority over incrementing.

Decomposition:
- Shared package: the FSM state encodings HZ_RUN, HZ_IWAIT and HZ_ISQUASH, plus the counter-saturate helper function.
- One sub-module, hazard_sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Load-use: d_mem_read_ex=1, write_reg_ex=2, use_rs=1, rs_id=2 -> pc_write=0, ir_write=0, bubblify=1, stall_cycles increments by 1.
- DATA_FORWARDING=0, RF_SELF_FORWARDING=0, reg_write_wb=1, write_reg_wb=3, rt_id=3, use_rt=1 -> stall. The same stimulus with the default parameters -> no stall.
- d_mem_busy held 3 cycles while branch_miss=1 -> stall_pipe=1 for 3 cycles, redirect_count unchanged. Next cycle: bubblify=1, flush_if=1, redirect_count=1.
- i_mem_busy 2 cycles, no redirect -> fsm_state=1, flush_if=1, pc_write=0 on both cycles. Third cycle returns RUN with incr_num_inst=1.
- jump_miss while i_mem_busy=1 -> fsm_state=2. The cycle i_mem_busy drops gives flush_if=1 and returns RUN. A DS in that cycle delays the squash by one cycle.
- Saturation/clear: CNT_W=2 with 5 stall cycles -> stall_cycles=3. Then count_clear plus a stall in the same cycle -> 0. Reset mid-ISQUASH -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM encodings and the
// saturating-counter helper.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_IWAIT   = 2'd1,
    HZ_ISQUASH = 2'd2
  } hz_state_e;

  // True when a counter of the given width already holds all-ones.
  function automatic logic hz_at_max(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (value >= max_val);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the ID-stage decoder/pipeline registers and the hazard unit.
// Valid/ready is not used: every signal is a level that is meaningful every cycle.
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
);
  logic                  use_rs, use_rt, use_rs_at_id;
  logic [REG_ADDR_W-1:0] rs_id, rt_id;
  logic                  reg_write_ex, reg_write_mem, reg_write_wb;
  logic [REG_ADDR_W-1:0] write_reg_ex, write_reg_mem, write_reg_wb;
  logic                  d_mem_read_ex, d_mem_read_mem, d_mem_read_wb;
  logic                  jump_miss, branch_miss;
  logic                  i_mem_busy, d_mem_busy;
  logic                  count_clear;
  logic                  pc_write, ir_write, bubblify, flush_if, stall_pipe, incr_num_inst;
  logic [CNT_W-1:0]      stall_cycles, redirect_count;
  logic [1:0]            fsm_state;

  modport master (
    output use_rs, use_rt, use_rs_at_id, rs_id, rt_id,
           reg_write_ex, reg_write_mem, reg_write_wb,
           write_reg_ex, write_reg_mem, write_reg_wb,
           d_mem_read_ex, d_mem_read_mem, d_mem_read_wb,
           jump_miss, branch_miss, i_mem_busy, d_mem_busy, count_clear,
    input  pc_write, ir_write, bubblify, flush_if, stall_pipe, incr_num_inst,
           stall_cycles, redirect_count, fsm_state
  );

  modport slave (
    input  use_rs, use_rt, use_rs_at_id, rs_id, rt_id,
           reg_write_ex, reg_write_mem, reg_write_wb,
           write_reg_ex, write_reg_mem, write_reg_wb,
           d_mem_read_ex, d_mem_read_mem, d_mem_read_wb,
           jump_miss, branch_miss, i_mem_busy, d_mem_busy, count_clear,
    output pc_write, ir_write, bubblify, flush_if, stall_pipe, incr_num_inst,
           stall_cycles, redirect_count, fsm_state
  );
endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter; clear wins over increment.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  import hazard_ctrl_unit_pkg::*;

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !hz_at_max(64'(count_q), CNT_W)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// ISA-independent pipeline hazard unit: data-stall detection, memory freeze,
// redirect handling with wrong-path fetch squashing, and performance counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W         = 2,
  parameter int DATA_FORWARDING    = 1,
  parameter int RF_SELF_FORWARDING = 1,
  parameter int CNT_W              = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_ctrl_unit_if.slave hz
);
  import hazard_ctrl_unit_pkg::*;

  hz_state_e             state_d, state_q;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic load_use, jump_dep, raw_fwd, raw_wb, ds;
  logic redirect, redirect_acc;
  logic pc_write, ir_write, bubblify, flush_if, stall_pipe;

  assign rs = hz.rs_id;
  assign rt = hz.rt_id;

  always_comb begin
    rs_ex  = hz.use_rs && (rs == hz.write_reg_ex);
    rt_ex  = hz.use_rt && (rt == hz.write_reg_ex);
    rs_mem = hz.use_rs && (rs == hz.write_reg_mem);
    rt_mem = hz.use_rt && (rt == hz.write_reg_mem);
    rs_wb  = hz.use_rs && (rs == hz.write_reg_wb);
    rt_wb  = hz.use_rt && (rt == hz.write_reg_wb);
    load_use = (rs_ex || rt_ex) && hz.d_mem_read_ex;
    // Register jumps read rs in ID, before any forwarding path can reach it.
    jump_dep = hz.use_rs_at_id &&
               ((hz.reg_write_ex && (rs == hz.write_reg_ex)) ||
                (hz.reg_write_mem && (rs == hz.write_reg_mem)));
    raw_fwd  = ((rs_ex || rt_ex) && hz.reg_write_ex) ||
               ((rs_mem || rt_mem) && (hz.reg_write_mem || hz.d_mem_read_mem));
    raw_wb   = (rs_wb || rt_wb) && (hz.reg_write_wb || hz.d_mem_read_wb);
    ds = load_use || jump_dep ||
         ((DATA_FORWARDING == 0) && raw_fwd) ||
         ((RF_SELF_FORWARDING == 0) && raw_wb);
  end

  assign redirect = hz.jump_miss || hz.branch_miss;

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    ir_write     = 1'b1;
    bubblify     = 1'b0;
    flush_if     = 1'b0;
    stall_pipe   = 1'b0;
    redirect_acc = 1'b0;
    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      bubblify = 1'b1;
      flush_if = 1'b1;
      state_d  = HZ_RUN;
    end else if (hz.d_mem_busy) begin
      stall_pipe = 1'b1;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
    end else if (ds) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      bubblify = 1'b1;
    end else if (redirect) begin
      flush_if     = 1'b1;
      bubblify     = hz.branch_miss;
      redirect_acc = 1'b1;
      state_d      = hz.i_mem_busy ? HZ_ISQUASH : HZ_RUN;
    end else if (hz.i_mem_busy) begin
      pc_write = 1'b0;
      flush_if = 1'b1;
      state_d  = (state_q == HZ_ISQUASH) ? HZ_ISQUASH : HZ_IWAIT;
    end else begin
      // The word arriving after a squashed fetch belongs to the wrong path.
      flush_if = (state_q == HZ_ISQUASH);
      state_d  = HZ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  assign hz.pc_write      = pc_write;
  assign hz.ir_write      = ir_write;
  assign hz.bubblify      = bubblify;
  assign hz.flush_if      = flush_if;
  assign hz.stall_pipe    = stall_pipe;
  assign hz.incr_num_inst = !(bubblify || flush_if || stall_pipe);
  assign hz.fsm_state     = state_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!reset && !pc_write),
    .clr   (hz.count_clear),
    .count (hz.stall_cycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_acc),
    .clr   (hz.count_clear),
    .count (hz.redirect_count)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a vector table for the combinational
// decisions plus hand-written sequences for the multi-cycle behaviour.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic       use_rs, use_rt, use_rs_at_id;
    logic [1:0] rs_id, rt_id;
    logic       rw_ex, rw_mem, rw_wb;
    logic [1:0] wr_ex, wr_mem, wr_wb;
    logic       ld_ex, ld_mem, ld_wb;
    logic       jmp, br, ibusy, dbusy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [5:0] exp_a;
    logic [5:0] exp_b;
  } vec_t;

  // {pc_write, ir_write, bubblify, flush_if, stall_pipe, incr_num_inst}
  localparam logic [5:0] C_RUN = 6'b110001;
  localparam logic [5:0] C_DS  = 6'b001000;
  localparam logic [5:0] C_FRZ = 6'b000010;
  localparam logic [5:0] C_JMP = 6'b110100;
  localparam logic [5:0] C_BR  = 6'b111100;
  localparam logic [5:0] C_IW  = 6'b010100;
  localparam logic [5:0] C_RST = 6'b001100;

  logic clk = 1'b0;
  logic reset;
  logic count_clear;
  in_t  cur;
  int   checks = 0;
  int   errors = 0;
  vec_t tab[14];

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_ADDR_W(2), .CNT_W(16)) if_a ();
  hazard_ctrl_unit_if #(.REG_ADDR_W(2), .CNT_W(16)) if_b ();
  hazard_ctrl_unit_if #(.REG_ADDR_W(2), .CNT_W(2))  if_c ();

  hazard_ctrl_unit #(.REG_ADDR_W(2), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(1), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .hz(if_a));
  hazard_ctrl_unit #(.REG_ADDR_W(2), .DATA_FORWARDING(0), .RF_SELF_FORWARDING(0), .CNT_W(16))
    dut_b (.clk(clk), .reset(reset), .hz(if_b));
  hazard_ctrl_unit #(.REG_ADDR_W(2), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(1), .CNT_W(2))
    dut_c (.clk(clk), .reset(reset), .hz(if_c));

  assign if_a.use_rs = cur.use_rs;             assign if_b.use_rs = cur.use_rs;             assign if_c.use_rs = cur.use_rs;
  assign if_a.use_rt = cur.use_rt;             assign if_b.use_rt = cur.use_rt;             assign if_c.use_rt = cur.use_rt;
  assign if_a.use_rs_at_id = cur.use_rs_at_id; assign if_b.use_rs_at_id = cur.use_rs_at_id; assign if_c.use_rs_at_id = cur.use_rs_at_id;
  assign if_a.rs_id = cur.rs_id;               assign if_b.rs_id = cur.rs_id;               assign if_c.rs_id = cur.rs_id;
  assign if_a.rt_id = cur.rt_id;               assign if_b.rt_id = cur.rt_id;               assign if_c.rt_id = cur.rt_id;
  assign if_a.reg_write_ex = cur.rw_ex;        assign if_b.reg_write_ex = cur.rw_ex;        assign if_c.reg_write_ex = cur.rw_ex;
  assign if_a.reg_write_mem = cur.rw_mem;      assign if_b.reg_write_mem = cur.rw_mem;      assign if_c.reg_write_mem = cur.rw_mem;
  assign if_a.reg_write_wb = cur.rw_wb;        assign if_b.reg_write_wb = cur.rw_wb;        assign if_c.reg_write_wb = cur.rw_wb;
  assign if_a.write_reg_ex = cur.wr_ex;        assign if_b.write_reg_ex = cur.wr_ex;        assign if_c.write_reg_ex = cur.wr_ex;
  assign if_a.write_reg_mem = cur.wr_mem;      assign if_b.write_reg_mem = cur.wr_mem;      assign if_c.write_reg_mem = cur.wr_mem;
  assign if_a.write_reg_wb = cur.wr_wb;        assign if_b.write_reg_wb = cur.wr_wb;        assign if_c.write_reg_wb = cur.wr_wb;
  assign if_a.d_mem_read_ex = cur.ld_ex;       assign if_b.d_mem_read_ex = cur.ld_ex;       assign if_c.d_mem_read_ex = cur.ld_ex;
  assign if_a.d_mem_read_mem = cur.ld_mem;     assign if_b.d_mem_read_mem = cur.ld_mem;     assign if_c.d_mem_read_mem = cur.ld_mem;
  assign if_a.d_mem_read_wb = cur.ld_wb;       assign if_b.d_mem_read_wb = cur.ld_wb;       assign if_c.d_mem_read_wb = cur.ld_wb;
  assign if_a.jump_miss = cur.jmp;             assign if_b.jump_miss = cur.jmp;             assign if_c.jump_miss = cur.jmp;
  assign if_a.branch_miss = cur.br;            assign if_b.branch_miss = cur.br;            assign if_c.branch_miss = cur.br;
  assign if_a.i_mem_busy = cur.ibusy;          assign if_b.i_mem_busy = cur.ibusy;          assign if_c.i_mem_busy = cur.ibusy;
  assign if_a.d_mem_busy = cur.dbusy;          assign if_b.d_mem_busy = cur.dbusy;          assign if_c.d_mem_busy = cur.dbusy;
  assign if_a.count_clear = count_clear;       assign if_b.count_clear = count_clear;       assign if_c.count_clear = count_clear;

  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {if_a.pc_write, if_a.ir_write, if_a.bubblify, if_a.flush_if, if_a.stall_pipe, if_a.incr_num_inst};
  assign ctl_b = {if_b.pc_write, if_b.ir_write, if_b.bubblify, if_b.flush_if, if_b.stall_pipe, if_b.incr_num_inst};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: drive on the falling edge, settle, caller then samples.
  task automatic cyc(input in_t v, input logic clr, input logic rst);
    @(negedge clk);
    cur         = v;
    count_clear = clr;
    reset       = rst;
    #1;
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  function automatic in_t lu();
    in_t v = '0;
    v.ld_ex = 1'b1; v.wr_ex = 2'd2; v.use_rs = 1'b1; v.rs_id = 2'd2;
    return v;
  endfunction

  function automatic in_t flag(input int which);
    in_t v = '0;
    case (which)
      0: v.jmp   = 1'b1;
      1: v.br    = 1'b1;
      2: v.ibusy = 1'b1;
      default: v.dbusy = 1'b1;
    endcase
    return v;
  endfunction

  task automatic fill_table();
    for (int k = 0; k < 14; k++) tab[k].i = '0;
    tab[0].exp_a = C_RUN;  tab[0].exp_b = C_RUN;
    tab[1].i = lu();
    tab[1].exp_a = C_DS;   tab[1].exp_b = C_DS;
    tab[2].i.ld_ex = 1; tab[2].i.wr_ex = 2; tab[2].i.use_rt = 1; tab[2].i.rt_id = 1;
    tab[2].exp_a = C_RUN;  tab[2].exp_b = C_RUN;
    tab[3].i.ld_ex = 1; tab[3].i.wr_ex = 2; tab[3].i.rs_id = 2;
    tab[3].exp_a = C_RUN;  tab[3].exp_b = C_RUN;
    tab[4].i.rw_wb = 1; tab[4].i.wr_wb = 3; tab[4].i.rt_id = 3; tab[4].i.use_rt = 1;
    tab[4].exp_a = C_RUN;  tab[4].exp_b = C_DS;
    tab[5].i.rw_ex = 1; tab[5].i.wr_ex = 1; tab[5].i.rs_id = 1; tab[5].i.use_rs = 1;
    tab[5].exp_a = C_RUN;  tab[5].exp_b = C_DS;
    tab[6].i.use_rs_at_id = 1; tab[6].i.rw_ex = 1; tab[6].i.wr_ex = 1; tab[6].i.rs_id = 1;
    tab[6].exp_a = C_DS;   tab[6].exp_b = C_DS;
    tab[7].i.use_rs_at_id = 1; tab[7].i.rw_mem = 1; tab[7].i.wr_mem = 3; tab[7].i.rs_id = 3;
    tab[7].exp_a = C_DS;   tab[7].exp_b = C_DS;
    tab[8].i.ld_mem = 1; tab[8].i.use_rt = 1;
    tab[8].exp_a = C_RUN;  tab[8].exp_b = C_DS;
    tab[9].i.jmp = 1;
    tab[9].exp_a = C_JMP;  tab[9].exp_b = C_JMP;
    tab[10].i.br = 1;
    tab[10].exp_a = C_BR;  tab[10].exp_b = C_BR;
    tab[11].i = lu(); tab[11].i.br = 1;
    tab[11].exp_a = C_DS;  tab[11].exp_b = C_DS;
    tab[12].i = lu(); tab[12].i.br = 1; tab[12].i.dbusy = 1;
    tab[12].exp_a = C_FRZ; tab[12].exp_b = C_FRZ;
    tab[13].i.ld_wb = 1; tab[13].i.wr_wb = 2; tab[13].i.use_rs = 1; tab[13].i.rs_id = 2;
    tab[13].exp_a = C_RUN; tab[13].exp_b = C_DS;
  endtask

  initial begin
    in_t v;
    reset = 1'b1; cur = '0; count_clear = 1'b0;
    fill_table();

    // Reset values.
    @(negedge clk); #1;
    check("rst_ctl", 32'(ctl_a), 32'(C_RST));
    check("rst_state", 32'(if_a.fsm_state), 32'd0);
    check("rst_stall_cnt", 32'(if_a.stall_cycles), 32'd0);
    check("rst_redir_cnt", 32'(if_a.redirect_count), 32'd0);
    cyc('0, 1'b0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      cyc(tab[k].i, 1'b0, 1'b0);
      check($sformatf("vec%0d_a", k), 32'(ctl_a), 32'(tab[k].exp_a));
      check($sformatf("vec%0d_b", k), 32'(ctl_b), 32'(tab[k].exp_b));
    end

    // Load-use stall counts one cycle.
    do_reset();
    cyc(lu(), 1'b0, 1'b0);
    check("lu_ctl", 32'(ctl_a), 32'(C_DS));
    cyc('0, 1'b0, 1'b0);
    check("lu_stall_cnt", 32'(if_a.stall_cycles), 32'd1);

    // Freeze holds a pending branch redirect.
    do_reset();
    v = flag(1); v.dbusy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(v, 1'b0, 1'b0);
      check($sformatf("frz%0d_ctl", k), 32'(ctl_a), 32'(C_FRZ));
    end
    cyc(flag(1), 1'b0, 1'b0);
    check("frz_br_ctl", 32'(ctl_a), 32'(C_BR));
    check("frz_redir_held", 32'(if_a.redirect_count), 32'd0);
    cyc('0, 1'b0, 1'b0);
    check("frz_redir_cnt", 32'(if_a.redirect_count), 32'd1);
    check("frz_stall_cnt", 32'(if_a.stall_cycles), 32'd3);

    // Fetch wait.
    do_reset();
    cyc(flag(2), 1'b0, 1'b0);
    check("iw1_ctl", 32'(ctl_a), 32'(C_IW));
    cyc(flag(2), 1'b0, 1'b0);
    check("iw2_ctl", 32'(ctl_a), 32'(C_IW));
    check("iw2_state", 32'(if_a.fsm_state), 32'd1);
    cyc('0, 1'b0, 1'b0);
    check("iw3_ctl", 32'(ctl_a), 32'(C_RUN));
    cyc('0, 1'b0, 1'b0);
    check("iw4_state", 32'(if_a.fsm_state), 32'd0);

    // Squash after a redirect during a busy fetch, delayed by a data stall.
    do_reset();
    v = flag(0); v.ibusy = 1'b1;
    cyc(v, 1'b0, 1'b0);
    check("sq1_ctl", 32'(ctl_a), 32'(C_JMP));
    v = flag(1); v.ibusy = 1'b1;
    cyc(v, 1'b0, 1'b0);
    check("sq2_state", 32'(if_a.fsm_state), 32'd2);
    check("sq2_ctl", 32'(ctl_a), 32'(C_BR));
    cyc(flag(2), 1'b0, 1'b0);
    check("sq3_state", 32'(if_a.fsm_state), 32'd2);
    check("sq3_ctl", 32'(ctl_a), 32'(C_IW));
    cyc(lu(), 1'b0, 1'b0);
    check("sq4_ctl", 32'(ctl_a), 32'(C_DS));
    cyc('0, 1'b0, 1'b0);
    check("sq5_state", 32'(if_a.fsm_state), 32'd2);
    check("sq5_ctl", 32'(ctl_a), 32'(C_JMP));
    cyc('0, 1'b0, 1'b0);
    check("sq6_state", 32'(if_a.fsm_state), 32'd0);
    check("sq6_ctl", 32'(ctl_a), 32'(C_RUN));

    // Saturation and clear on the narrow counter.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(lu(), 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    check("sat_stall_cnt", 32'(if_c.stall_cycles), 32'd3);
    check("wide_stall_cnt", 32'(if_a.stall_cycles), 32'd5);
    cyc(lu(), 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);
    check("clr_stall_cnt_c", 32'(if_c.stall_cycles), 32'd0);
    check("clr_stall_cnt_a", 32'(if_a.stall_cycles), 32'd0);

    // Reset in the middle of a squash.
    v = flag(0); v.ibusy = 1'b1;
    cyc(v, 1'b0, 1'b0);
    cyc(flag(2), 1'b0, 1'b0);
    check("rsq_state", 32'(if_a.fsm_state), 32'd2);
    cyc(flag(2), 1'b0, 1'b1);
    check("rsq_rst_ctl", 32'(ctl_a), 32'(C_RST));
    cyc('0, 1'b0, 1'b0);
    check("rsq_state_run", 32'(if_a.fsm_state), 32'd0);
    check("rsq_stall_cnt", 32'(if_a.stall_cycles), 32'd0);
    check("rsq_redir_cnt", 32'(if_a.redirect_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
